// File: rtl/set_job_responder.sv
// Queued set-job responder: requests {val, drive, dly} are buffered in a FIFO
// and applied to a registered output one at a time after their programmed delay.
//
// state | meaning
// IDLE  | no job in flight; pops the FIFO head when one is queued
// WAIT  | counting down the popped job's delay, applies it at cnt == 0
module set_job_responder #(
    parameter int DEPTH = 4,
    parameter int DLY_W = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_val,
    input  logic                     req_drive,
    input  logic [DLY_W-1:0]         req_dly,
    output logic                     out_val,
    output logic                     out_en,
    output logic                     done,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int EW = DLY_W + 2;
    localparam logic [AW:0]      LVL_FULL = (AW + 1)'(DEPTH);
    localparam logic [AW:0]      LVL_ONE  = (AW + 1)'(1);
    localparam logic [AW-1:0]    PTR_ONE  = AW'(1);
    localparam logic [DLY_W-1:0] CNT_ONE  = DLY_W'(1);

    typedef enum logic {IDLE, WAIT} state_t;

    logic [EW-1:0]    mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    state_t           state;
    logic [DLY_W-1:0] cnt;
    logic             job_val;
    logic             job_drive;
    logic             push;
    logic             pop;

    // Ready depends on registered occupancy only, so a full FIFO refuses a
    // push even on the edge that frees an entry.
    assign req_ready = (level != LVL_FULL);
    assign push      = req_valid && req_ready;
    assign pop       = (state == IDLE) && (level != '0);
    assign busy      = (state != IDLE) || (level != '0);

    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            mem[wr_ptr] <= {req_val, req_drive, req_dly};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            state     <= IDLE;
            cnt       <= '0;
            job_val   <= 1'b0;
            job_drive <= 1'b0;
            out_val   <= 1'b0;
            out_en    <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;

            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   level <= level + LVL_ONE;
                2'b01:   level <= level - LVL_ONE;
                default: level <= level;
            endcase

            case (state)
                IDLE: begin
                    if (pop) begin
                        {job_val, job_drive, cnt} <= mem[rd_ptr];
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_ONE;
                    end else begin
                        out_val <= job_val;
                        out_en  <= job_drive;
                        done    <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_set_job_responder.sv
// Bench for set_job_responder: directed scenarios followed by random traffic,
// checked against a job-timeline model (each job's pop and apply edge computed up front).
module tb_set_job_responder;

    localparam int DEPTH = 4;
    localparam int DLY_W = 4;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic             req_val = 1'b0;
    logic             req_drive = 1'b0;
    logic [DLY_W-1:0] req_dly = '0;
    logic             out_val;
    logic             out_en;
    logic             done;
    logic             busy;
    logic [LW-1:0]    level;

    always #5 clk = ~clk;

    set_job_responder #(.DEPTH(DEPTH), .DLY_W(DLY_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_val   (req_val),
        .req_drive (req_drive),
        .req_dly   (req_dly),
        .out_val   (out_val),
        .out_en    (out_en),
        .done      (done),
        .busy      (busy),
        .level     (level)
    );

    // A job leaves the FIFO one edge after both its accept edge and the
    // previous job's apply edge, then applies dly+1 edges after that.
    typedef struct {
        int pop;
        int app;
        bit val;
        bit drv;
    } job_t;

    job_t jobs[$];
    int   last_app = -1;
    int   n = 0;
    int   tests = 0;
    int   fails = 0;
    int   m_level = 0;
    bit   m_val = 1'b0;
    bit   m_en = 1'b0;
    bit   m_done = 1'b0;
    bit   m_busy = 1'b0;
    bit   acc;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s at edge %0d: got %0h expected %0h", tag, n, obs, exp);
        end
    endtask

    task automatic eval_model();
        m_done  = 1'b0;
        m_level = 0;
        m_busy  = 1'b0;
        foreach (jobs[i]) begin
            if (jobs[i].app == n) begin
                m_val  = jobs[i].val;
                m_en   = jobs[i].drv;
                m_done = 1'b1;
            end
            if (jobs[i].pop > n) m_level++;
            if (jobs[i].pop <= n && n < jobs[i].app) m_busy = 1'b1;
        end
        if (m_level != 0) m_busy = 1'b1;
        while (jobs.size() > 0 && jobs[0].app <= n) void'(jobs.pop_front());
    endtask

    task automatic step(input bit rst, input bit v, input bit val, input bit drv,
                        input logic [DLY_W-1:0] dly, output bit accepted);
        job_t j;
        rst_n     = ~rst;
        req_valid = v;
        req_val   = val;
        req_drive = drv;
        req_dly   = dly;
        accepted  = !rst && v && (m_level != DEPTH);
        @(posedge clk);
        n++;
        if (rst) begin
            jobs.delete();
            last_app = -1;
            m_val    = 1'b0;
            m_en     = 1'b0;
        end else if (accepted) begin
            j.pop = ((n > last_app) ? n : last_app) + 1;
            j.app = j.pop + int'(dly) + 1;
            j.val = val;
            j.drv = drv;
            last_app = j.app;
            jobs.push_back(j);
        end
        eval_model();
        @(negedge clk);
        check("level", 8'(level), 8'(m_level));
        check("req_ready", 8'(req_ready), 8'(m_level != DEPTH));
        check("done", 8'(done), 8'(m_done));
        check("out_val", 8'(out_val), 8'(m_val));
        check("out_en", 8'(out_en), 8'(m_en));
        check("busy", 8'(busy), 8'(m_busy));
    endtask

    task automatic idle(input int cycles);
        bit a;
        for (int i = 0; i < cycles; i++) step(1'b0, 1'b0, 1'b0, 1'b0, '0, a);
    endtask

    task automatic push_held(input bit val, input bit drv, input logic [DLY_W-1:0] dly);
        bit a;
        a = 1'b0;
        for (int t = 0; t < 40 && !a; t++) step(1'b0, 1'b1, val, drv, dly, a);
        tests++;
        if (!a) begin
            fails++;
            $error("FAIL push_timeout at edge %0d: got no accept expected accept", n);
        end
    endtask

    initial begin
        // reset with a request presented: must not be accepted
        step(1'b1, 1'b1, 1'b1, 1'b1, 4'd1, acc);
        step(1'b1, 1'b1, 1'b1, 1'b1, 4'd1, acc);
        idle(2);

        // immediate drive-high job
        step(1'b0, 1'b1, 1'b1, 1'b1, 4'd0, acc);
        idle(4);

        // release job with delay 3
        step(1'b0, 1'b1, 1'b0, 1'b0, 4'd3, acc);
        idle(7);

        // five back-to-back jobs, fifth held through the full/pop edge
        push_held(1'b1, 1'b1, 4'd2);
        push_held(1'b0, 1'b1, 4'd2);
        push_held(1'b1, 1'b0, 4'd2);
        push_held(1'b1, 1'b1, 4'd2);
        push_held(1'b0, 1'b1, 4'd2);
        idle(25);

        // reset mid-WAIT with two jobs queued
        push_held(1'b1, 1'b1, 4'd8);
        push_held(1'b0, 1'b1, 4'd8);
        push_held(1'b1, 1'b1, 4'd8);
        idle(2);
        step(1'b1, 1'b1, 1'b1, 1'b1, 4'd0, acc);
        idle(25);

        // maximum delay
        step(1'b0, 1'b1, 1'b1, 1'b1, 4'd15, acc);
        idle(20);

        for (int i = 0; i < 500; i++) begin
            bit rst_r;
            logic [DLY_W-1:0] d;
            rst_r = ($urandom_range(0, 99) == 0);
            d = ($urandom_range(0, 7) == 0) ? DLY_W'($urandom_range(0, 15))
                                            : DLY_W'($urandom_range(0, 3));
            step(rst_r, $urandom_range(0, 2) != 0, 1'($urandom), 1'($urandom), d, acc);
        end
        idle(30);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/set_job_responder.md
SET_JOB_RESPONDER -- requirements
Module: set_job_responder

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning request FIFO depth in entries (power of two, 2..16).
REQ-002 The block SHALL have parameter DLY_W, default 4, meaning width of the per-request delay field.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, reset: synchronous, active-low.
REQ-005 The block SHALL have port req_valid, input, 1, meaning the initiator presents a set request.
REQ-006 The block SHALL have port req_ready, output, 1, meaning the FIFO can accept a request this cycle.
REQ-007 The block SHALL have port req_val, input, 1, meaning the value to drive.
REQ-008 The block SHALL have port req_drive, input, 1, meaning 1 = drive req_val and 0 = release the output (high-Z intent).
REQ-009 The block SHALL have port req_dly, input, DLY_W, meaning the wait cycles before the request is applied.
REQ-010 The block SHALL have port out_val, output, 1, meaning the registered output value.
REQ-011 The block SHALL have port out_en, output, 1, meaning the registered output enable (0 = released).
REQ-012 The block SHALL have port done, output, 1, meaning a one-cycle pulse after each request is applied.
REQ-013 The block SHALL have port busy, output, 1, meaning high when FSM != IDLE or FIFO non-empty.
REQ-014 The block SHALL have port level, output, $clog2(DEPTH)+1, meaning the current FIFO occupancy.

Function
REQ-015 A request SHALL be accepted on a rising edge where req_valid && req_ready; {req_val, req_drive, req_dly} written to FIFO tail.
REQ-016 req_ready SHALL equal (level != DEPTH), from registered state only; no combinational path from req_valid.
REQ-017 When full, a push SHALL be refused even if a pop occurs on the same edge.
REQ-018 The FSM SHALL have states IDLE and WAIT.
REQ-019 In IDLE with level != 0, the next edge SHALL pop the FIFO head, load cnt = req_dly, and go to WAIT.
REQ-020 In IDLE with level == 0, the FSM SHALL stay in IDLE and hold outputs.
REQ-021 In WAIT with cnt != 0, cnt SHALL decrement by 1 per edge.
REQ-022 In WAIT with cnt == 0, the next edge SHALL load out_val = val and out_en = drive, set done = 1, and return to IDLE.
REQ-023 Latency from the accept edge of a request into an empty, IDLE block to its apply edge SHALL be req_dly + 2 edges.
REQ-024 Consecutive queued requests SHALL be applied with req_dly + 2 edges between successive apply edges.
REQ-025 done SHALL be high only during the cycle following an apply edge; otherwise 0.
REQ-026 With drive = 0, out_val SHALL still be loaded with val; consumers qualify out_val with out_en.
REQ-027 Requests SHALL be applied strictly in acceptance order.
REQ-028 A simultaneous push and pop SHALL leave level unchanged.
REQ-029 FIFO pointers SHALL wrap modulo DEPTH.
REQ-030 req_dly at its maximum (2^DLY_W - 1) SHALL produce the full wait with no counter overflow.

Reset
REQ-031 While rst_n == 0 at a rising edge, the block SHALL set FIFO empty (level = 0), FSM = IDLE, cnt = 0, out_val = 0, out_en = 0, done = 0.
REQ-032 Reset SHALL discard any in-progress WAIT job and all queued requests with no apply and no done.
REQ-033 During reset, req_ready SHALL reflect level = 0 (high) but no request SHALL be accepted.
REQ-034 After reset, the first accepted request SHALL follow REQ-023 timing exactly.

Verification
REQ-035 Reset, then one request {val = 1, drive = 1, dly = 0} accepted at edge 0 -> out_en = 1, out_val = 1 after edge 2; done high for one cycle.
REQ-036 Request {val = 0, drive = 0, dly = 3} accepted at edge 0 -> outputs unchanged through edge 4; out_en = 0 after edge 5; done pulses.
REQ-037 Push 5 requests back-to-back with DEPTH = 4 and dly = 2 -> req_ready low once level = 4, fifth accepted after first pop, applies in order at 4-edge spacing.
REQ-038 Full FIFO with req_valid held during pop edge -> no accept on that edge; level 4 -> 3; accept on next edge.
REQ-039 Assert rst_n = 0 mid-WAIT with 2 queued -> after reset edge level = 0, out_en = 0, no done; no later apply of the discarded jobs.
REQ-040 dly = 15 with DLY_W = 4 -> apply exactly 17 edges after the accept edge.
